divisor_frequencia_param: RTL and testbench
===========================================

Name: divisor_frequencia_param

Overview:
- Parametrised, runtime-programmable clock divider for the access-control system.
- Successor to the fixed 1 Hz divider chain: one counter replaces the cascade, and the divisor can be reloaded while running without glitches.
- Generates a square enable (clk_out) and a single-cycle tick at sys_clk / N.
- Feeds the timers, display multiplexing and gate-timeout logic.

Parameters:
- WIDTH, 26, counter and divisor width in bits (2^26 > 50 000 000).
- DIV_DEFAULT, 50000000, divisor loaded at reset; gives 1 Hz from 50 MHz. Must be >= 2.

Ports:
- clk  input  1  system clock, 50 MHz nominal.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; when low, the divider freezes.
- div_load  input  1  one-cycle strobe; requests a new divisor.
- div_val  input  WIDTH  new divisor N, sampled when div_load=1.
- clk_out  output  1  registered square output, period N clk cycles.
- tick  output  1  one-cycle pulse per period.
- div_pend  output  1  a divisor is stored but not yet applied.
- div_err  output  1  one-cycle pulse: the last load was rejected.

Behaviour:
- All state changes on the rising edge of clk. Reset is synchronous and active-high: clock is clk, reset is rst.
- Reset values:
  - cnt=0, active divisor A=DIV_DEFAULT.
  - pending P=0, div_pend=0.
  - clk_out=0, tick=0, div_err=0.
- Counting, when en=1:
  - cnt_next = (cnt==A-1) ? 0 : cnt+1. This is the wrap event.
  - clk_out <= (cnt_next >= L), where L = floor(A_next/2). A_next is the divisor in force after this edge.
  - tick <= 1 exactly on the edge where cnt wraps; otherwise 0.
  - tick is therefore high during the first cycle of each period, coinciding with the falling edge of clk_out.
- Duty cycle:
  - Even N: low N/2 cycles, high N/2 cycles.
  - Odd N: low floor(N/2) cycles, high ceil(N/2) cycles.
- When en=0:
  - cnt and clk_out hold.
  - tick <= 0.
  - Loads are still accepted.
- Divisor load (div_load=1):
  - If div_val < 2: reject. div_err <= 1 for one cycle; P and div_pend are unchanged.
  - Otherwise: P <= div_val, div_pend <= 1.
  - A second load while pending overwrites P; the last value wins.
- Apply:
  - At a wrap edge with div_pend=1: A <= P, div_pend <= 0.
  - The new divisor governs cnt from value 0 onward, so there are no truncated or runt periods.
- Same-cycle load and wrap:
  - A valid div_val is bypassed straight into A at that wrap, and div_pend ends 0.
  - An invalid div_val pulses div_err, and any older P is applied.
- Arithmetic:
  - Unsigned WIDTH-bit throughout.
  - A-1 and the comparisons never underflow, because A >= 2 is guaranteed.
- Reset mid-period:
  - Counting restarts from cnt=0 with DIV_DEFAULT on the next cycle.
  - Any pending divisor is discarded.

Optional Feature:
- Macro: DIVISOR_SYNC_CLR_EN.
- Defined:
  - Adds input port sync_clr (1 bit).
  - When sync_clr=1, on the next edge: cnt<=0, clk_out<=0, tick<=0.
  - Any pending P is applied immediately (A<=P, div_pend<=0).
  - Priority: rst > sync_clr > normal counting. This lets several dividers be phase-aligned.
- Undefined:
  - Port absent; behaviour exactly as above.

Test Plan (bench overrides DIV_DEFAULT=10, WIDTH=8):
- Reset, then en=1 for 40 cycles. Expect:
  - clk_out low 5, high 5, repeating.
  - tick at cycles 10, 20, 30 after release.
  - div_pend=0, div_err=0.
- At cnt=3, pulse div_load with div_val=7. Expect:
  - div_pend=1 until the wrap at cycle 10.
  - Next periods are 7 cycles: low 3, high 4.
  - No runt period.
- Pulse div_val=1, then div_val=0. Expect:
  - div_err pulses once for each load.
  - Period stays 10; div_pend stays 0.
- Pulse div_load with div_val=4 on the exact wrap cycle. Expect:
  - The following period is already 4 (low 2, high 2).
  - div_pend never observed high.
- Drop en for 6 cycles mid-period. Expect:
  - cnt and clk_out frozen; tick=0.
  - The period resumes and completes with total enabled cycles = 10.
- Load 6, then assert rst before the wrap. Expect:
  - div_pend=0 and period 10 after reset.
  - With DIVISOR_SYNC_CLR_EN: a separate run loads 6, then pulses sync_clr at cnt=2. Expect clk_out=0, tick=0, and 6-cycle periods starting immediately.

Source files
------------

// File: rtl/divisor_frequencia_param.sv
// Runtime-programmable clock divider: square clk_out and one-cycle tick at clk/N, glitch-free divisor reload.
// Build with DIVISOR_SYNC_CLR_EN defined to add the sync_clr phase-alignment input.
module divisor_frequencia_param #(
  parameter int WIDTH       = 26,
  parameter int DIV_DEFAULT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef DIVISOR_SYNC_CLR_EN
  input  logic             sync_clr,
`endif
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pend,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] pend_val;

  logic             clr;
  logic             load_ok;
  logic             load_bad;
  logic             wrap;
  logic [WIDTH-1:0] next_div;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] act_nxt;
  logic             clk_nxt;

`ifdef DIVISOR_SYNC_CLR_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    load_ok  = div_load && (div_val >= WIDTH'(2));
    load_bad = div_load && (div_val <  WIDTH'(2));
    wrap     = (cnt == (act - WIDTH'(1)));

    // Divisor taken at a period boundary: a same-cycle valid load beats the stored one.
    if (load_ok) begin
      next_div = div_val;
    end else if (div_pend) begin
      next_div = pend_val;
    end else begin
      next_div = act;
    end

    cnt_nxt = wrap ? '0 : (cnt + WIDTH'(1));
    act_nxt = wrap ? next_div : act;
    clk_nxt = (cnt_nxt >= (act_nxt >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      act      <= DIV_RST;
      pend_val <= '0;
      div_pend <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_err <= load_bad;
      if (clr) begin
        cnt      <= '0;
        clk_out  <= 1'b0;
        tick     <= 1'b0;
        act      <= next_div;
        div_pend <= 1'b0;
      end else if (en) begin
        cnt     <= cnt_nxt;
        clk_out <= clk_nxt;
        tick    <= wrap;
        act     <= act_nxt;
        if (wrap) begin
          div_pend <= 1'b0;
        end else if (load_ok) begin
          pend_val <= div_val;
          div_pend <= 1'b1;
        end
      end else begin
        // Frozen: counter and output hold, loads still queue up.
        tick <= 1'b0;
        if (load_ok) begin
          pend_val <= div_val;
          div_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_divisor_frequencia_param.sv
// Scoreboard bench for divisor_frequencia_param with WIDTH=8, DIV_DEFAULT=10.
module tb_divisor_frequencia_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sync_clr;
  logic         div_load;
  logic [W-1:0] div_val;
  logic         clk_out;
  logic         tick;
  logic         div_pend;
  logic         div_err;

  divisor_frequencia_param #(.WIDTH(W), .DIV_DEFAULT(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
`ifdef DIVISOR_SYNC_CLR_EN
    .sync_clr (sync_clr),
`endif
    .div_load (div_load),
    .div_val  (div_val),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_pend (div_pend),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic out;
    logic tck;
    logic pend;
    logic err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  logic pend_seen = 1'b0;

  int   m_cnt, m_a, m_p;
  logic m_pend, m_out, m_tick, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference behaviour evaluated from the inputs about to be sampled.
  task automatic model(output exp_t e);
    logic good, bad;
    good = div_load && (div_val >= 2);
    bad  = div_load && (div_val < 2);
    if (rst) begin
      m_cnt = 0; m_a = 10; m_p = 0; m_pend = 0;
      m_out = 0; m_tick = 0; m_err = 0;
    end else begin
      m_err = bad;
      if (sync_clr) begin
        m_cnt = 0; m_out = 0; m_tick = 0;
        if (good) m_a = div_val;
        else if (m_pend) m_a = m_p;
        m_pend = 0;
      end else if (en) begin
        if (m_cnt == m_a - 1) begin
          m_cnt = 0; m_tick = 1;
          if (good) m_a = div_val;
          else if (m_pend) m_a = m_p;
          m_pend = 0;
        end else begin
          m_cnt++; m_tick = 0;
          if (good) begin m_p = div_val; m_pend = 1; end
        end
        m_out = (m_cnt >= m_a / 2);
      end else begin
        m_tick = 0;
        if (good) begin m_p = div_val; m_pend = 1; end
      end
    end
    e.out = m_out; e.tck = m_tick; e.pend = m_pend; e.err = m_err;
  endtask

  task automatic step();
    exp_t e;
    model(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cyc++;
    check("clk_out",  {31'b0, clk_out},  {31'b0, e.out});
    check("tick",     {31'b0, tick},     {31'b0, e.tck});
    check("div_pend", {31'b0, div_pend}, {31'b0, e.pend});
    check("div_err",  {31'b0, div_err},  {31'b0, e.err});
    if (div_err) err_cnt++;
    if (div_pend) pend_seen = 1'b1;
  endtask

  task automatic load(input int v);
    div_load = 1'b1;
    div_val  = W'(v);
    step();
    div_load = 1'b0;
    div_val  = '0;
  endtask

  task automatic count_to_tick(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (tick) return;
    end
    check("tick_timeout", 0, 1);
  endtask

  // Call while sitting in a tick cycle; measures that period.
  task automatic measure(output int len, output int hi);
    len = 1;
    hi  = int'(clk_out);
    for (int i = 0; i < 200; i++) begin
      step();
      if (tick) return;
      len++;
      hi += int'(clk_out);
    end
    check("period_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int tick_cyc[$];
  int len, hi, n;

  initial begin
    rst = 1'b1; en = 1'b0; sync_clr = 1'b0; div_load = 1'b0; div_val = '0;
    step();
    step();
    check("rst_clk_out",  {31'b0, clk_out},  0);
    check("rst_tick",     {31'b0, tick},     0);
    check("rst_div_pend", {31'b0, div_pend}, 0);

    // Free run at the default divisor.
    rst = 1'b0; en = 1'b1; cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick) tick_cyc.push_back(cyc);
    end
    check("tick_count", tick_cyc.size(), 4);
    check("tick_1", tick_cyc[0], 10);
    check("tick_2", tick_cyc[1], 20);
    check("tick_3", tick_cyc[2], 30);

    // Rejected loads (sitting in a tick cycle, cnt=0).
    err_cnt = 0;
    load(1);
    load(0);
    check("err_pulses", err_cnt, 2);
    check("pend_after_bad", {31'b0, div_pend}, 0);
    count_to_tick(n);
    measure(len, hi);
    check("len_after_bad", len, 10);
    check("hi_after_bad", hi, 5);

    // Load 7 at cnt=3.
    step(); step(); step();
    load(7);
    check("pend_after_load", {31'b0, div_pend}, 1);
    count_to_tick(n);
    check("cycles_to_apply", n, 6);
    measure(len, hi);
    check("len7_a", len, 7);
    check("hi7_a", hi, 4);
    measure(len, hi);
    check("len7_b", len, 7);
    check("hi7_b", hi, 4);

    // Load 4 on the wrap edge itself.
    for (int i = 0; i < 6; i++) step();
    pend_seen = 1'b0;
    load(4);
    check("tick_on_bypass", {31'b0, tick}, 1);
    measure(len, hi);
    check("len4", len, 4);
    check("hi4", hi, 2);
    check("pend_never_seen", {31'b0, pend_seen}, 0);

    // Enable dropped for 6 cycles mid-period.
    do_reset();
    for (int i = 0; i < 6; i++) step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("frozen_clk_out", {31'b0, clk_out}, 1);
      check("frozen_tick", {31'b0, tick}, 0);
    end
    en = 1'b1;
    count_to_tick(n);
    check("enabled_total", 6 + n, 10);

    // Load then reset before it is applied.
    step();
    load(6);
    check("pend_before_rst", {31'b0, div_pend}, 1);
    do_reset();
    check("pend_after_rst", {31'b0, div_pend}, 0);
    count_to_tick(n);
    check("first_after_rst", n, 10);
    measure(len, hi);
    check("len_after_rst", len, 10);
    check("hi_after_rst", hi, 5);

`ifdef DIVISOR_SYNC_CLR_EN
    do_reset();
    load(6);
    step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("sclr_clk_out", {31'b0, clk_out}, 0);
    check("sclr_tick", {31'b0, tick}, 0);
    check("sclr_pend", {31'b0, div_pend}, 0);
    count_to_tick(n);
    check("sclr_first", n, 6);
    measure(len, hi);
    check("sclr_len", len, 6);
    check("sclr_hi", hi, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
